// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer driven by the data_clk phase of the SCL stretch generator.
// Optional build macro I2C_NACK_ABORT_EN: a slave NACK forces STOP on the next data_clk rise.
module i2c_master_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl_not_ena,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              ack_error
);

  localparam int CNT_MAX = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    READY, START, COMMAND, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
  } state_e;

  state_e            state_q, state_d;
  logic              dclk_q;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   addr_rw_q, addr_rw_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;
  logic              sda_oe_q, sda_oe_d;
  logic              scl_ne_q, scl_ne_d;
  logic              busy_q, busy_d;
  logic              ack_err_q, ack_err_d;

  logic              rise, fall, cnt_zero, same_target, nack_abort;
  logic [CW-1:0]     cnt_m1;
  logic [ADDR_W:0]   req_addr_rw;

  assign rise        = data_clk & ~dclk_q;
  assign fall        = ~data_clk & dclk_q;
  assign cnt_zero    = (bit_cnt_q == '0);
  assign cnt_m1      = bit_cnt_q - 1'b1;
  assign req_addr_rw = {addr, rw};
  assign same_target = (req_addr_rw == addr_rw_q);

  // ack_error is cleared at every START, so while set it can only hold a NACK of this transfer.
`ifdef I2C_NACK_ABORT_EN
  assign nack_abort = ack_err_q;
`else
  assign nack_abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_rw_d = addr_rw_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rd_d = data_rd_q;
    sda_oe_d  = sda_oe_q;
    scl_ne_d  = scl_ne_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;

    // bit_cnt tracks the index of the bit currently on SDA while transmitting.
    if (rise) begin
      case (state_q)
        READY: begin
          if (ena) begin
            addr_rw_d = req_addr_rw;
            tx_d      = data_wr;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b1;
            state_d   = START;
          end else begin
            busy_d = 1'b0;
          end
        end
        START: begin
          busy_d    = 1'b1;
          sda_oe_d  = ~addr_rw_q[ADDR_W];
          bit_cnt_d = CW'(ADDR_W);
          state_d   = COMMAND;
        end
        COMMAND: begin
          busy_d = 1'b1;
          if (cnt_zero) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = CW'(DATA_W - 1);
            state_d   = SLV_ACK1;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_oe_d  = ~addr_rw_q[cnt_m1];
          end
        end
        SLV_ACK1: begin
          bit_cnt_d = CW'(DATA_W - 1);
          if (nack_abort) begin
            sda_oe_d = 1'b1;
            state_d  = STOP;
          end else if (addr_rw_q[0]) begin
            sda_oe_d = 1'b0;
            state_d  = RD;
          end else begin
            sda_oe_d = ~tx_q[DATA_W-1];
            state_d  = WR;
          end
        end
        WR: begin
          busy_d = 1'b1;
          if (cnt_zero) begin
            sda_oe_d = 1'b0;
            state_d  = SLV_ACK2;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_oe_d  = ~tx_q[cnt_m1];
          end
        end
        RD: begin
          busy_d = 1'b1;
          if (cnt_zero) begin
            sda_oe_d  = ena & same_target;
            bit_cnt_d = CW'(DATA_W - 1);
            state_d   = MSTR_ACK;
          end else begin
            bit_cnt_d = cnt_m1;
          end
        end
        SLV_ACK2, MSTR_ACK: begin
          if (nack_abort && state_q == SLV_ACK2) begin
            sda_oe_d = 1'b1;
            state_d  = STOP;
          end else if (ena) begin
            busy_d    = 1'b0;
            addr_rw_d = req_addr_rw;
            tx_d      = data_wr;
            bit_cnt_d = CW'(DATA_W - 1);
            if (!same_target) begin
              sda_oe_d = 1'b0;
              state_d  = START;
            end else if (addr_rw_q[0]) begin
              sda_oe_d = 1'b0;
              state_d  = RD;
            end else begin
              sda_oe_d = ~data_wr[DATA_W-1];
              state_d  = WR;
            end
          end else begin
            sda_oe_d = 1'b1;
            state_d  = STOP;
          end
        end
        STOP: begin
          busy_d   = 1'b0;
          sda_oe_d = 1'b0;
          state_d  = READY;
        end
        default: state_d = READY;
      endcase
    end else if (fall) begin
      case (state_q)
        START: begin
          scl_ne_d  = 1'b0;
          ack_err_d = 1'b0;
        end
        SLV_ACK1, SLV_ACK2: ack_err_d = ack_err_q | sda_in;
        RD: begin
          rx_d[bit_cnt_q] = sda_in;
          if (cnt_zero) data_rd_d = rx_d;
        end
        STOP: scl_ne_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    dclk_q <= data_clk;
    if (rst) begin
      state_q   <= READY;
      bit_cnt_q <= CW'(DATA_W - 1);
      addr_rw_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rd_q <= '0;
      sda_oe_q  <= 1'b0;
      scl_ne_q  <= 1'b1;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_rw_q <= addr_rw_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rd_q <= data_rd_d;
      sda_oe_q  <= sda_oe_d;
      scl_ne_q  <= scl_ne_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign scl_not_ena = scl_ne_q;
  assign busy        = busy_q;
  assign data_rd     = data_rd_q;
  assign ack_error   = ack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: drives data_clk phases and a simple slave on sda_in.
module tb_i2c_master_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_clk = 1'b0;
  logic       ena = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] data_wr = '0;
  logic       sda_in = 1'b1;
  logic       sda_oe, scl_not_ena, busy, ack_error;
  logic [7:0] data_rd;

  int checks = 0;
  int failures = 0;

  i2c_master_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .data_clk(data_clk), .ena(ena), .addr(addr), .rw(rw),
    .data_wr(data_wr), .sda_in(sda_in), .sda_oe(sda_oe), .scl_not_ena(scl_not_ena),
    .busy(busy), .data_rd(data_rd), .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  // One data_clk period; outputs are sampled late in the high phase.
  task automatic dcyc(input logic sin, output logic oe, output logic bz, output logic sne);
    sda_in = sin;
    @(negedge clk) data_clk = 1'b1;
    repeat (4) @(negedge clk);
    oe = sda_oe; bz = busy; sne = scl_not_ena;
    data_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; data_clk = 1'b0; ena = 1'b0; sda_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ena = 1'b1; addr = 7'h50; data_wr = 8'hA5;
    repeat (2) @(negedge clk);
    data_clk = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (scl_not_ena !== 1'b1) begin failures++; $display("FAIL reset_scl_ne got=%b exp=1", scl_not_ena); end
    checks++; if (data_rd !== 8'h00) begin failures++; $display("FAIL reset_data_rd got=%h exp=00", data_rd); end
    checks++; if (ack_error !== 1'b0) begin failures++; $display("FAIL reset_ack_error got=%b exp=0", ack_error); end
    data_clk = 1'b0; ena = 1'b0;
    do_reset();
  endtask

  task automatic test_write();
    logic oe, bz, sne;
    logic [7:0] b;
    logic sne1;
    do_reset();
    addr = 7'h50; rw = 1'b0; data_wr = 8'hA5; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz} !== 2'b11) begin failures++; $display("FAIL wr_start oe_busy got=%b exp=11", {oe, bz}); end
    ena = 1'b0;
    sne1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe;
      if (i == 0) sne1 = sne;
    end
    checks++; if (sne1 !== 1'b0) begin failures++; $display("FAIL wr_scl_enabled got=%b exp=0", sne1); end
    checks++; if (b !== 8'hA0) begin failures++; $display("FAIL wr_addr_byte got=%h exp=a0", b); end
    dcyc(1'b0, oe, bz, sne);
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL wr_ack1_release got=%b exp=0", oe); end
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'hA5) begin failures++; $display("FAIL wr_data_byte got=%h exp=a5", b); end
    dcyc(1'b0, oe, bz, sne);
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL wr_ack2_release got=%b exp=0", oe); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL wr_stop_low got=%b exp=1", oe); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz, sne, ack_error} !== 4'b0010) begin
      failures++; $display("FAIL wr_stop_idle oe_busy_sne_ackerr got=%b exp=0010", {oe, bz, sne, ack_error}); end
  endtask

  task automatic test_read();
    logic oe, bz, sne, any_drive;
    logic [7:0] b;
    logic [7:0] rdv;
    rdv = 8'h5A;
    do_reset();
    addr = 7'h3C; rw = 1'b1; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'h79) begin failures++; $display("FAIL rd_addr_byte got=%h exp=79", b); end
    dcyc(1'b0, oe, bz, sne);
    any_drive = 1'b0;
    for (int i = 0; i < 8; i++) begin dcyc(rdv[7-i], oe, bz, sne); any_drive |= oe; end
    checks++; if (any_drive !== 1'b0) begin failures++; $display("FAIL rd_sda_released got=%b exp=0", any_drive); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if (data_rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", data_rd); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL rd_master_nack got=%b exp=0", oe); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL rd_stop_low got=%b exp=1", oe); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz, sne} !== 3'b001) begin failures++; $display("FAIL rd_stop_idle got=%b exp=001", {oe, bz, sne}); end
  endtask

  task automatic test_addr_nack();
    logic oe, bz, sne;
    logic [7:0] b;
    do_reset();
    addr = 7'h50; rw = 1'b0; data_wr = 8'h3C; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    ena = 1'b0;
    for (int i = 0; i < 8; i++) dcyc(1'b1, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    checks++; if (ack_error !== 1'b1) begin failures++; $display("FAIL nack_ack_error got=%b exp=1", ack_error); end
`ifdef I2C_NACK_ABORT_EN
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL nack_abort_stop got=%b exp=1", oe); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz, sne} !== 3'b001) begin failures++; $display("FAIL nack_abort_idle got=%b exp=001", {oe, bz, sne}); end
`else
    b[7] = ~oe;
    for (int i = 1; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'h3C) begin failures++; $display("FAIL nack_continue_data got=%h exp=3c", b); end
    dcyc(1'b0, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({bz, sne, ack_error} !== 3'b011) begin
      failures++; $display("FAIL nack_continue_end busy_sne_ackerr got=%b exp=011", {bz, sne, ack_error}); end
`endif
  endtask

  task automatic test_back_to_back();
    logic oe, bz, sne;
    logic [7:0] b;
    int lows;
    do_reset();
    addr = 7'h50; rw = 1'b0; data_wr = 8'h11; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    data_wr = 8'h22;
    lows = 0;
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0; end
    dcyc(1'b0, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; lows += (bz == 1'b0) ? 1 : 0; end
    checks++; if (b !== 8'h11) begin failures++; $display("FAIL b2b_byte1 got=%h exp=11", b); end
    dcyc(1'b0, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0;
    dcyc(1'b1, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0;
    checks++; if (bz !== 1'b0) begin failures++; $display("FAIL b2b_busy_pulse got=%b exp=0", bz); end
    b[7] = ~oe;
    ena = 1'b0;
    for (int i = 1; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; lows += (bz == 1'b0) ? 1 : 0; end
    checks++; if (b !== 8'h22) begin failures++; $display("FAIL b2b_byte2 got=%h exp=22", b); end
    dcyc(1'b0, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0;
    dcyc(1'b1, oe, bz, sne); lows += (bz == 1'b0) ? 1 : 0;
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL b2b_stop_low got=%b exp=1", oe); end
    checks++; if (lows != 1) begin failures++; $display("FAIL b2b_busy_low_count got=%0d exp=1", lows); end
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz, sne} !== 3'b001) begin failures++; $display("FAIL b2b_idle got=%b exp=001", {oe, bz, sne}); end
  endtask

  task automatic test_repeated_start();
    logic oe, bz, sne;
    logic [7:0] b;
    do_reset();
    addr = 7'h50; rw = 1'b0; data_wr = 8'h33; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    addr = 7'h51; rw = 1'b1;
    for (int i = 0; i < 8; i++) dcyc(1'b1, oe, bz, sne);
    dcyc(1'b0, oe, bz, sne);
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'h33) begin failures++; $display("FAIL rs_first_data got=%h exp=33", b); end
    dcyc(1'b0, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz} !== 2'b00) begin failures++; $display("FAIL rs_release_busy got=%b exp=00", {oe, bz}); end
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'hA3) begin failures++; $display("FAIL rs_new_addr got=%h exp=a3", b); end
    ena = 1'b0;
    dcyc(1'b0, oe, bz, sne);
    checks++; if ({oe, bz} !== 2'b01) begin failures++; $display("FAIL rs_ack_release got=%b exp=01", {oe, bz}); end
  endtask

  task automatic test_reset_mid();
    logic oe, bz, sne;
    logic [7:0] b;
    do_reset();
    addr = 7'h50; rw = 1'b0; data_wr = 8'hA5; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    ena = 1'b0;
    for (int i = 0; i < 8; i++) dcyc(1'b1, oe, bz, sne);
    dcyc(1'b0, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    dcyc(1'b1, oe, bz, sne);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL mid_pre_reset_bit got=%b exp=1", oe); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({sda_oe, scl_not_ena, busy} !== 3'b010) begin
      failures++; $display("FAIL mid_reset_outputs got=%b exp=010", {sda_oe, scl_not_ena, busy}); end
    rst = 1'b0;
    @(negedge clk);
    addr = 7'h2A; rw = 1'b0; data_wr = 8'h0F; ena = 1'b1;
    dcyc(1'b1, oe, bz, sne);
    checks++; if ({oe, bz} !== 2'b11) begin failures++; $display("FAIL mid_restart got=%b exp=11", {oe, bz}); end
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin dcyc(1'b1, oe, bz, sne); b[7-i] = ~oe; end
    checks++; if (b !== 8'h54) begin failures++; $display("FAIL mid_restart_addr got=%h exp=54", b); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_repeated_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
